// File: rtl/ama_riscv_hpm_unit_pkg.sv
// Shared HPM definitions: CSR addresses, event selector type, event and half enums.
package ama_riscv_hpm_unit_pkg;

  localparam logic [11:0] CSR_MHPMCOUNTER   = 12'hB00;
  localparam logic [11:0] CSR_MHPMCOUNTERH  = 12'hB80;
  localparam logic [11:0] CSR_MHPMEVENT     = 12'h320;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_HPM_OVF       = 12'h7C0;
  localparam logic [11:0] CSR_HPM_IRQ_EN    = 12'h7C1;

  localparam int HPM_EVT_SEL_W = 4;
  typedef logic [HPM_EVT_SEL_W-1:0] hpm_evt_sel_t;

  // Bit order of perf_event (bit k = event k+1)
  typedef enum logic [2:0] {
    HPM_EVT_BAD_SPEC,
    HPM_EVT_BE,
    HPM_EVT_BE_DC,
    HPM_EVT_FE,
    HPM_EVT_FE_IC,
    HPM_EVT_RET_SIMD
  } hpm_evt_idx_t;

  typedef enum logic {
    HPM_HALF_LO,
    HPM_HALF_HI
  } hpm_half_t;

endpackage

// File: rtl/ama_riscv_hpm_unit_if.sv
// CSR-side bus between the CSR block (master) and the HPM unit (slave).
interface ama_riscv_hpm_unit_if;
  logic        csr_re;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;

  modport master (output csr_re, csr_we, csr_addr, csr_wdata, input csr_rdata, csr_hit);
  modport slave  (input csr_re, csr_we, csr_addr, csr_wdata, output csr_rdata, csr_hit);
endinterface

// File: rtl/ama_riscv_hpm_counter.sv
// One HPM counter: event select match, inhibit, split-half write, overflow pulse.
// HPM_EVT_PIPE_EN registers the select match one stage ahead of the increment.
module ama_riscv_hpm_counter
  import ama_riscv_hpm_unit_pkg::*;
#(
  parameter int CNT_W     = 64,
  parameter int NUM_EVT   = 8,
  parameter int EVT_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVT_SEL_W-1:0] evt_sel,
  input  logic [NUM_EVT-1:0]   perf_event,
  input  logic                 inhibit,
  input  logic                 wr_en,
  input  hpm_half_t            wr_half,
  input  logic [31:0]          wdata,
  output logic [CNT_W-1:0]     cnt,
  output logic                 ovf_pulse
);

  logic match, inc_src, inc;

  // Selector 0 and values above NUM_EVT never match
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_EVT; k++)
      if (evt_sel == EVT_SEL_W'(k + 1)) match = perf_event[k];
  end

`ifdef HPM_EVT_PIPE_EN
  logic match_q;
  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match;
  end
  assign inc_src = match_q;
`else
  assign inc_src = match;
`endif

  assign inc       = inc_src & ~inhibit & ~wr_en;
  assign ovf_pulse = inc & (&cnt);

  always_ff @(posedge clk) begin
    if (rst)                                 cnt <= '0;
    else if (wr_en && wr_half == HPM_HALF_LO) cnt[31:0] <= wdata;
    else if (wr_en)                          cnt[CNT_W-1:32] <= wdata[CNT_W-33:0];
    else if (inc)                            cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ama_riscv_hpm_unit.sv
// HPM bank: NUM_CNT event counters, selectors, mcountinhibit, W1C overflow and irq.
// Optional HPM_EVT_PIPE_EN adds one stage of event latency inside each counter.
module ama_riscv_hpm_unit
  import ama_riscv_hpm_unit_pkg::*;
#(
  parameter int NUM_CNT   = 6,
  parameter int IDX_L     = 3,
  parameter int CNT_W     = 64,
  parameter int NUM_EVT   = 8,
  parameter int EVT_SEL_W = HPM_EVT_SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  ama_riscv_hpm_unit_if.slave bus,
  input  logic [NUM_EVT-1:0]  perf_event,
  output logic                ovf_irq
);

  logic [NUM_CNT-1:0]                hit_lo, hit_hi, hit_evt;
  logic                              hit_inh, hit_ovf, hit_ien, acc, we;
  logic [NUM_CNT-1:0][EVT_SEL_W-1:0] evt_sel;
  logic [NUM_CNT-1:0][CNT_W-1:0]     cnt;
  logic [NUM_CNT-1:0]                inh, ovf, irq_en, ovf_pulse, wbits;
  logic [31:0]                       rdata;

  assign acc   = bus.csr_re | bus.csr_we;
  assign we    = bus.csr_we;
  assign wbits = bus.csr_wdata[IDX_L +: NUM_CNT];

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      hit_lo[i]  = bus.csr_addr == CSR_MHPMCOUNTER  + 12'(IDX_L + i);
      hit_hi[i]  = bus.csr_addr == CSR_MHPMCOUNTERH + 12'(IDX_L + i);
      hit_evt[i] = bus.csr_addr == CSR_MHPMEVENT    + 12'(IDX_L + i);
    end
    hit_inh = bus.csr_addr == CSR_MCOUNTINHIBIT;
    hit_ovf = bus.csr_addr == CSR_HPM_OVF;
    hit_ien = bus.csr_addr == CSR_HPM_IRQ_EN;
  end

  assign bus.csr_hit = acc & ((|hit_lo) | (|hit_hi) | (|hit_evt) | hit_inh | hit_ovf | hit_ien);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    ama_riscv_hpm_counter #(
      .CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .EVT_SEL_W(EVT_SEL_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .evt_sel    (evt_sel[i]),
      .perf_event (perf_event),
      .inhibit    (inh[i]),
      .wr_en      (we & (hit_lo[i] | hit_hi[i])),
      .wr_half    (hit_hi[i] ? HPM_HALF_HI : HPM_HALF_LO),
      .wdata      (bus.csr_wdata),
      .cnt        (cnt[i]),
      .ovf_pulse  (ovf_pulse[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_sel <= '0;
      inh     <= '0;
      irq_en  <= '0;
      ovf     <= '0;
      ovf_irq <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++)
        if (we && hit_evt[i]) evt_sel[i] <= bus.csr_wdata[EVT_SEL_W-1:0];
      if (we && hit_inh) inh    <= wbits;
      if (we && hit_ien) irq_en <= wbits;
      // Set wins over a same-cycle W1C of the same bit
      ovf     <= (ovf & ~({NUM_CNT{we & hit_ovf}} & wbits)) | ovf_pulse;
      ovf_irq <= |(ovf & irq_en);
    end
  end

  // Mask registers are stored compactly and re-aligned to architectural bit positions
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (hit_lo[i])  rdata = cnt[i][31:0];
      if (hit_hi[i])  rdata = 32'(cnt[i][CNT_W-1:32]);
      if (hit_evt[i]) rdata = 32'(evt_sel[i]);
    end
    if (hit_inh) rdata = 32'(inh) << IDX_L;
    if (hit_ovf) rdata = 32'(ovf) << IDX_L;
    if (hit_ien) rdata = 32'(irq_en) << IDX_L;
  end

  assign bus.csr_rdata = bus.csr_hit ? rdata : 32'h0;

endmodule

// File: tb/tb_ama_riscv_hpm_unit.sv
// Scoreboard bench for ama_riscv_hpm_unit: reads push expectations, a negedge monitor checks them.
module tb_ama_riscv_hpm_unit;

`ifdef HPM_EVT_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic        irq;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] perf_event;
  logic       ovf_irq;
  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  ama_riscv_hpm_unit_if bus();

  ama_riscv_hpm_unit dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .perf_event (perf_event),
    .ovf_irq    (ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lat_step();
    if (PIPE) step();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we = 1'b1; bus.csr_addr = a; bus.csr_wdata = d;
    step();
    bus.csr_we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic h,
                    input logic irq, input string nm);
    exp_t e;
    e.data = d; e.hit = h; e.irq = irq; e.name = nm;
    sb.push_back(e);
    bus.csr_re = 1'b1; bus.csr_addr = a;
    step();
    bus.csr_re = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.csr_re) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: addr=%h data=%h with no expectation queued", bus.csr_addr, bus.csr_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.csr_rdata !== e.data || bus.csr_hit !== e.hit || ovf_irq !== e.irq) begin
          n_fail++;
          $display("FAIL %s: got data=%h hit=%b irq=%b, expected data=%h hit=%b irq=%b",
                   e.name, bus.csr_rdata, bus.csr_hit, ovf_irq, e.data, e.hit, e.irq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; perf_event = '0;
    bus.csr_re = 1'b0; bus.csr_we = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    rd(12'hB03, 32'h0, 1'b1, 1'b0, "rst_cnt3_lo");
    rd(12'h323, 32'h0, 1'b1, 1'b0, "rst_evt3");
    rd(12'h320, 32'h0, 1'b1, 1'b0, "rst_inhibit");
    rd(12'h7C0, 32'h0, 1'b1, 1'b0, "rst_ovf");
    rd(12'h7C1, 32'h0, 1'b1, 1'b0, "rst_irq_en");

    // counter 3 counts 5 pulses of event 1
    wr(12'h323, 32'h1);
    perf_event = 8'h01;
    repeat (5) step();
    perf_event = 8'h00;
    step();
    rd(12'hB03, 32'd5, 1'b1, 1'b0, "cnt3_lo_5");
    rd(12'hB83, 32'd0, 1'b1, 1'b0, "cnt3_hi_0");
    rd(12'hB04, 32'd0, 1'b1, 1'b0, "cnt4_idle");
    rd(12'hB08, 32'd0, 1'b1, 1'b0, "cnt8_idle");

    // counter 4 wraps, ovf bit 4, registered irq, W1C
    wr(12'h324, 32'h2);
    wr(12'hB04, 32'hFFFF_FFFE);
    wr(12'hB84, 32'hFFFF_FFFF);
    wr(12'h7C1, 32'h10);
    rd(12'hB84, 32'hFFFF_FFFF, 1'b1, 1'b0, "cnt4_hi_preload");
    perf_event = 8'h02;
    step(); step();
    perf_event = 8'h00;
    lat_step();
    rd(12'h7C0, 32'h10, 1'b1, 1'b0, "ovf_set_irq_not_yet");
    rd(12'h7C0, 32'h10, 1'b1, 1'b1, "ovf_irq_high");
    rd(12'hB04, 32'h0, 1'b1, 1'b1, "cnt4_wrap_lo");
    rd(12'hB84, 32'h0, 1'b1, 1'b1, "cnt4_wrap_hi");
    wr(12'h7C0, 32'h10);
    rd(12'h7C0, 32'h0, 1'b1, 1'b1, "ovf_cleared_irq_lag");
    rd(12'h7C0, 32'h0, 1'b1, 1'b0, "irq_dropped");

    // counter 5 inhibited while event 3 stays high
    wr(12'h325, 32'h3);
    wr(12'h320, 32'h20);
    rd(12'h320, 32'h20, 1'b1, 1'b0, "inhibit_bit5");
    perf_event = 8'h04;
    repeat (10) step();
    rd(12'hB05, 32'h0, 1'b1, 1'b0, "cnt5_inhibited");
    wr(12'h320, 32'h0);
    rd(12'hB05, 32'h0, 1'b1, 1'b0, "cnt5_resume_0");
    rd(12'hB05, 32'h1, 1'b1, 1'b0, "cnt5_resume_1");
    rd(12'hB05, 32'h2, 1'b1, 1'b0, "cnt5_resume_2");
    perf_event = 8'h00;
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h0000_01F8, 1'b1, 1'b0, "inhibit_mask");
    wr(12'h320, 32'h0);

    // counter 6: write to low half beats simultaneous event
    wr(12'h326, 32'h4);
    wr(12'hB86, 32'hABCD);
    perf_event = 8'h08;
    repeat (3) step();
    wr(12'hB06, 32'h1234);
    perf_event = 8'h00;
    step();
    rd(12'hB06, PIPE ? 32'h1235 : 32'h1234, 1'b1, 1'b0, "cnt6_write_wins");
    rd(12'hB86, 32'hABCD, 1'b1, 1'b0, "cnt6_hi_kept");

    // out-of-range selector and unmapped addresses
    wr(12'h327, 32'hF);
    rd(12'h327, 32'hF, 1'b1, 1'b0, "evt7_readback");
    perf_event = 8'hFF;
    repeat (4) step();
    perf_event = 8'h00;
    step();
    rd(12'hB07, 32'h0, 1'b1, 1'b0, "cnt7_never_counts");
    rd(12'hB1F, 32'h0, 1'b0, 1'b0, "unmapped_b1f");
    rd(12'hB09, 32'h0, 1'b0, 1'b0, "above_range_b09");
    rd(12'hB02, 32'h0, 1'b0, 1'b0, "below_range_b02");
    rd(12'h7C1, 32'h10, 1'b1, 1'b0, "irq_en_readback");

    // single-pulse latency on counter 8
    wr(12'h328, 32'h5);
    perf_event = 8'h10;
    step();
    perf_event = 8'h00;
    rd(12'hB08, PIPE ? 32'h0 : 32'h1, 1'b1, 1'b0, "cnt8_t_plus_1");
    rd(12'hB08, 32'h1, 1'b1, 1'b0, "cnt8_t_plus_2");

    // reset mid-count discards that cycle's events
    perf_event = 8'h01;
    rst = 1'b1;
    step();
    rst = 1'b0;
    perf_event = 8'h00;
    step();
    rd(12'hB03, 32'h0, 1'b1, 1'b0, "rst_mid_cnt3");
    rd(12'h323, 32'h0, 1'b1, 1'b0, "rst_mid_evt3");
    rd(12'h7C1, 32'h0, 1'b1, 1'b0, "rst_mid_irq_en");
    rd(12'hB86, 32'h0, 1'b1, 1'b0, "rst_mid_cnt6_hi");

    step();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
